// File: rtl/clock_repl_pkg.sv
// rtl/clock_repl_pkg.sv - shared types and helpers for the CLOCK replacement engine
package clock_repl_pkg;

    localparam int CLOCK_ASSOC = 4;
    // rotl1 works on a fixed-width carrier; ways per set must stay below this.
    localparam int ROT_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } evict_state_e;

    typedef struct packed {
        logic [CLOCK_ASSOC-1:0] hand;
        logic [CLOCK_ASSOC-1:0] use_bits;
        logic [CLOCK_ASSOC-1:0] valid;
    } clock_set_t;

    function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                   input int unsigned w);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            r[6'((i + 1) % w)] = v[6'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_victim_select.sv
// rtl/clock_victim_select.sv - combinational CLOCK victim pick for one set
module clock_victim_select
    import clock_repl_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4
) (
    input  logic [ASSOCIATIVITY-1:0] hand_i,
    input  logic [ASSOCIATIVITY-1:0] use_i,
    input  logic [ASSOCIATIVITY-1:0] valid_i,
    input  logic                     inv_first_i,
    output logic [ASSOCIATIVITY-1:0] victim_o,
    output logic [ASSOCIATIVITY-1:0] use_o,
    output logic [ASSOCIATIVITY-1:0] hand_o,
    output logic                     was_invalid_o
);

    localparam int A  = ASSOCIATIVITY;
    localparam int A2 = 2 * ASSOCIATIVITY;
    localparam logic [A-1:0]  ONE  = 1;
    localparam logic [A2-1:0] ONE2 = 1;

    logic [A-1:0]  invalid;
    logic [A-1:0]  inv_lowest;
    logic [A-1:0]  free;
    logic [A-1:0]  at_or_above;
    logic [A2-1:0] scan;
    logic [A2-1:0] scan_first;
    logic [A2-1:0] passed2;
    logic [A-1:0]  passed;
    logic [A-1:0]  clk_victim;
    logic [ROT_MAX_W-1:0] rot_w;
    logic          unused_rot;

    assign invalid    = ~valid_i;
    assign inv_lowest = invalid & (~invalid + ONE);

    // Doubled free vector with ways below the hand masked in the lower copy,
    // so a single find-first-one yields the circular scan from the hand.
    assign free        = ~use_i;
    assign at_or_above = ~(hand_i - ONE);
    assign scan        = {free, free & at_or_above};
    assign scan_first  = scan & (~scan + ONE2);
    assign passed2     = scan_first - {{A{1'b0}}, hand_i};
    assign passed      = passed2[A-1:0] | passed2[A2-1:A];
    assign clk_victim  = (|free) ? (scan_first[A-1:0] | scan_first[A2-1:A]) : hand_i;

    assign rot_w      = rotl1(ROT_MAX_W'(clk_victim), ASSOCIATIVITY);
    assign unused_rot = ^rot_w[ROT_MAX_W-1:A];

    always_comb begin
        victim_o      = clk_victim;
        use_o         = (|free) ? ((use_i & ~passed) | clk_victim) : clk_victim;
        hand_o        = rot_w[A-1:0];
        was_invalid_o = |(clk_victim & invalid);
        if (inv_first_i && (|invalid)) begin
            victim_o      = inv_lowest;
            use_o         = use_i | inv_lowest;
            hand_o        = hand_i;
            was_invalid_o = 1'b1;
        end
    end

endmodule

// File: rtl/clock_repl_set_array.sv
// rtl/clock_repl_set_array.sv - multi-set CLOCK replacement engine with victim handshake
// Optional invalid-first victim selection: CLOCK_REPL_INVALID_FIRST_EN.
module clock_repl_set_array
    import clock_repl_pkg::*;
#(
    parameter  int ASSOCIATIVITY = 4,
    parameter  int NUM_SETS      = 16,
    localparam int SET_W         = $clog2(NUM_SETS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_touch_valid,
    input  logic [SET_W-1:0]         i_touch_set,
    input  logic [ASSOCIATIVITY-1:0] i_touch_way,
    input  logic                     i_inval_valid,
    input  logic [SET_W-1:0]         i_inval_set,
    input  logic [ASSOCIATIVITY-1:0] i_inval_way,
    input  logic                     i_evict_req_valid,
    output logic                     o_evict_req_ready,
    input  logic [SET_W-1:0]         i_evict_set,
    output logic                     o_evict_resp_valid,
    input  logic                     i_evict_resp_ready,
    output logic [ASSOCIATIVITY-1:0] o_evict_way,
    output logic                     o_evict_was_invalid
);

    localparam int A = ASSOCIATIVITY;
    localparam logic [A-1:0] HAND_RST = 1;
`ifdef CLOCK_REPL_INVALID_FIRST_EN
    localparam logic INV_FIRST = 1'b1;
`else
    localparam logic INV_FIRST = 1'b0;
`endif

    logic [A-1:0] hand_q  [NUM_SETS];
    logic [A-1:0] use_q   [NUM_SETS];
    logic [A-1:0] valid_q [NUM_SETS];
    logic [A-1:0] hand_d  [NUM_SETS];
    logic [A-1:0] use_d   [NUM_SETS];
    logic [A-1:0] valid_d [NUM_SETS];
    logic [A-1:0] ops_use   [NUM_SETS];
    logic [A-1:0] ops_valid [NUM_SETS];

    evict_state_e state_q, state_d;
    logic [A-1:0] resp_way_q, resp_way_d;
    logic         resp_inv_q, resp_inv_d;

    logic         accept;
    logic         resp_done;
    logic [A-1:0] sel_victim;
    logic [A-1:0] sel_use;
    logic [A-1:0] sel_hand;
    logic         sel_inv;

    assign o_evict_req_ready   = (state_q == IDLE);
    assign o_evict_resp_valid  = (state_q == RESP);
    assign o_evict_way         = resp_way_q;
    assign o_evict_was_invalid = resp_inv_q;
    assign accept              = i_evict_req_valid & o_evict_req_ready;
    assign resp_done           = o_evict_resp_valid & i_evict_resp_ready;

    // Touch/invalidate effects per set; invalidate is applied first so it wins.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            ops_valid[s] = valid_q[s];
            ops_use[s]   = use_q[s];
            if (i_inval_valid && (i_inval_set == SET_W'(s))) begin
                ops_valid[s] = valid_q[s] & ~i_inval_way;
                ops_use[s]   = use_q[s] & ~i_inval_way;
            end
            if (i_touch_valid && (i_touch_set == SET_W'(s))) begin
                ops_use[s] = ops_use[s] | (i_touch_way & ops_valid[s]);
            end
        end
    end

    clock_victim_select #(
        .ASSOCIATIVITY(ASSOCIATIVITY)
    ) u_select (
        .hand_i       (hand_q[i_evict_set]),
        .use_i        (ops_use[i_evict_set]),
        .valid_i      (ops_valid[i_evict_set]),
        .inv_first_i  (INV_FIRST),
        .victim_o     (sel_victim),
        .use_o        (sel_use),
        .hand_o       (sel_hand),
        .was_invalid_o(sel_inv)
    );

    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            hand_d[s]  = hand_q[s];
            use_d[s]   = ops_use[s];
            valid_d[s] = ops_valid[s];
            if (accept && (i_evict_set == SET_W'(s))) begin
                hand_d[s]  = sel_hand;
                use_d[s]   = sel_use;
                valid_d[s] = ops_valid[s] | sel_victim;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_way_d = resp_way_q;
        resp_inv_d = resp_inv_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = RESP;
                    resp_way_d = sel_victim;
                    resp_inv_d = sel_inv;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            resp_way_q <= '0;
            resp_inv_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                hand_q[s]  <= HAND_RST;
                use_q[s]   <= '0;
                valid_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            resp_way_q <= resp_way_d;
            resp_inv_q <= resp_inv_d;
            for (int s = 0; s < NUM_SETS; s++) begin
                hand_q[s]  <= hand_d[s];
                use_q[s]   <= use_d[s];
                valid_q[s] <= valid_d[s];
            end
        end
    end

endmodule

// File: doc/clock_repl_set_array.md
Name: clock_repl_set_array

Overview:
- Sequential, multi-set CLOCK replacement engine for the set-associative caches.
- Holds per-set hand pointer, use bits and valid bits.
- Accepts hit "touches", invalidations and victim requests from the cache controller.
- Returns a one-hot victim way through a valid/ready handshake and commits hand/use/valid updates atomically on request acceptance.

Parameters:
- ASSOCIATIVITY, 4, ways per set (>=2, any integer).
- NUM_SETS, 16, number of sets (>=2).
- SET_W, $clog2(NUM_SETS), localparam, set-index width.

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_touch_valid  input  1  hit touch strobe
- i_touch_set  input  SET_W  set of touched way
- i_touch_way  input  ASSOCIATIVITY  one-hot touched way
- i_inval_valid  input  1  invalidate strobe
- i_inval_set  input  SET_W  set to invalidate in
- i_inval_way  input  ASSOCIATIVITY  one-hot way to invalidate
- i_evict_req_valid  input  1  victim request valid
- o_evict_req_ready  output  1  request accepted when valid&ready
- i_evict_set  input  SET_W  set needing a victim
- o_evict_resp_valid  output  1  victim response valid
- i_evict_resp_ready  input  1  consumer accepts response
- o_evict_way  output  ASSOCIATIVITY  one-hot victim way
- o_evict_was_invalid  output  1  victim was an invalid way (no writeback needed)

Behaviour:
- Reset: every set gets hand=way0 (one-hot 1), U=0, V=0. FSM=IDLE. o_evict_resp_valid=0, o_evict_way=0, o_evict_was_invalid=0. Reset mid-RESP drops the pending response; o_evict_resp_valid is low the cycle after reset.
- FSM has two states, IDLE and RESP.
  - o_evict_req_ready = (state==IDLE).
  - IDLE->RESP on req accept.
  - RESP->IDLE on o_evict_resp_valid & i_evict_resp_ready.
  - One victim in flight; peak throughput is 1 per 2 cycles.
- Latency: victim is computed and registered at the accept edge. o_evict_resp_valid rises next cycle. o_evict_way and o_evict_was_invalid are held stable until the handshake completes.
- Touch (any state): U[set] |= way. Ignored if the way is invalid.
- Invalidate (any state): V[set] &= ~way and U[set] &= ~way.
- Victim selection for set S, with hand H, use U, valid V, computed from bypassed state:
  - Invalid-first (when enabled): if ~V != 0, victim = lowest-index invalid way. was_invalid=1. H unchanged. No U bits cleared.
  - Otherwise, circular scan starting at H: victim = first way with U=0 at or after H. Every way passed (from H up to but excluding the victim) gets U cleared. If all U=1, victim=H and all other U bits are cleared. Implement with a doubled 2*ASSOCIATIVITY vector and find-first-one; no loops over time.
- Commit at the accept edge: U[victim]=1, V[victim]=1. For a clock-path victim, H = victim rotated left by 1, wrapping way N-1 -> way0.
- Simultaneous events:
  - Same-cycle invalidate, then touch, to the request's set are applied before victim selection (bypass).
  - Invalidate beats touch on the same set/way.
  - A touch to another set proceeds independently in the same cycle.
  - A touch or invalidate to set S while in RESP updates the arrays but never alters the held response.
- State storage is flop arrays indexed by set. All three ports may hit different sets in the same cycle.

Optional Feature:
- Macro CLOCK_REPL_INVALID_FIRST_EN.
- Defined: the invalid-first rule above applies.
- Undefined: V is still tracked and drives o_evict_was_invalid (=~V[victim] before commit), but selection always uses the clock scan, including for invalid ways.

Decomposition:
- Package clock_repl_pkg holds:
  - FSM state enum evict_state_e {IDLE, RESP}.
  - Struct clock_set_t {hand, use, valid} parameterised by ASSOCIATIVITY via a localparam.
  - Helper function rotl1.
- One sub-module, clock_victim_select: purely combinational. Inputs are hand, use, valid and an invalid-first control. Outputs are victim mask, next use, next hand and was_invalid. Reusable by other cache levels.

Test Plan:
- Post-reset, feature on, A=4: evict set 3 four times -> 0001, 0010, 0100, 1000, all with was_invalid=1. Fifth evict -> 0001, was_invalid=0, U=0001, H=0010.
- All valid, U=1011, H=0010 -> victim 0100, U=1101, H=1000.
- Wrap: U=1101, H=0100 -> victim 0010, U=0010, H=0100.
- Backpressure: hold i_evict_resp_ready=0 for 3 cycles -> resp valid and way stable, req_ready=0. Touches during the hold update U. On ready, IDLE next cycle.
- Bypass: U=1110, H=0001, touch way0 same cycle as accept -> victim 0001, U=0001, H=0010. Same-cycle invalidate way2 with feature on -> victim 0100, was_invalid=1.
- Assert i_rst while in RESP -> resp_valid=0 next cycle. Re-evict any set -> 0001 with was_invalid=1. Repeat the first scenario without the macro -> same ways, since the clock scan on U=0 yields the same order.
